viterbi_decoder: RTL and testbench

- Hard-decision, rate-1/2, constraint-length-3 Viterbi decoder.
- Sits directly downstream of the convolutional encoder and consumes its 2-bit code symbol `c` (generators 7/5 octal) one symbol per accepted cycle.
- Emits one decoded bit per accepted symbol after a fixed decision delay.
- Uses four add-compare-select (ACS) units and register-exchange survivor memory.

---
 rtl/viterbi_pkg.sv | 31 +++
 rtl/viterbi_acs.sv | 51 +++++
 rtl/viterbi_decoder.sv | 165 ++++++++++++++++
 tb/tb_viterbi_decoder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// ----------------------------------------------------------------------------
// viterbi_pkg
// Shared constants and helper functions for the K=3, rate-1/2 hard-decision
// Viterbi decoder (generators 7/5 octal).
//   NUM_STATES    : trellis states (2^(K-1))
//   K             : constraint length
//   G0, G1        : generator taps applied to {b, s1, s2}
//   expected_sym  : code symbol produced leaving 'state' on input bit 'b'
//   branch_metric : Hamming distance between received and expected symbols
// ----------------------------------------------------------------------------
package viterbi_pkg;

   localparam int NUM_STATES = 4;
   localparam int K = 3;
   localparam logic [K-1:0] G0 = 3'b111;
   localparam logic [K-1:0] G1 = 3'b101;

   // state = {s1, s2}; the encoder register seen by the taps is {b, s1, s2}.
   function automatic logic [1:0] expected_sym(input logic [1:0] state, input logic b);
      logic [K-1:0] sr;
      sr = {b, state};
      return {^(sr & G0), ^(sr & G1)};
   endfunction

   function automatic logic [1:0] branch_metric(input logic [1:0] rx, input logic [1:0] ex);
      logic [1:0] d;
      d = rx ^ ex;
      return {1'b0, d[1]} + {1'b0, d[0]};
   endfunction

endpackage

// File: rtl/viterbi_acs.sv
// ----------------------------------------------------------------------------
// viterbi_acs
// Add-compare-select for one destination state.
//   pm0 / bm0 : metric of predecessor {s1,0} and its branch metric
//   pm1 / bm1 : metric of predecessor {s1,1} and its branch metric
//   pm_new    : winning candidate, saturated at 2^PM_W-1
//   dec       : 1 when predecessor {s1,1} wins; ties go to {s1,0}
// ----------------------------------------------------------------------------
module viterbi_acs #(
   parameter int PM_W = 4
) (
   input  logic [PM_W-1:0] pm0,
   input  logic [PM_W-1:0] pm1,
   input  logic [1:0]      bm0,
   input  logic [1:0]      bm1,
   output logic [PM_W-1:0] pm_new,
   output logic            dec
);

   localparam logic [PM_W:0]   SUM_MAX = {1'b0, {PM_W{1'b1}}};
   localparam logic [PM_W-1:0] PM_MAX  = {PM_W{1'b1}};

   logic [PM_W:0]   sum0_s;
   logic [PM_W:0]   sum1_s;
   logic [PM_W-1:0] cand0_s;
   logic [PM_W-1:0] cand1_s;

   // Saturating add of both candidates, then pick the smaller one.
   always_comb begin
      sum0_s = {1'b0, pm0} + {{(PM_W-1){1'b0}}, bm0};
      sum1_s = {1'b0, pm1} + {{(PM_W-1){1'b0}}, bm1};
      if (sum0_s > SUM_MAX) begin
         cand0_s = PM_MAX;
      end else begin
         cand0_s = sum0_s[PM_W-1:0];
      end
      if (sum1_s > SUM_MAX) begin
         cand1_s = PM_MAX;
      end else begin
         cand1_s = sum1_s[PM_W-1:0];
      end
      if (cand1_s < cand0_s) begin
         pm_new = cand1_s;
         dec    = 1'b1;
      end else begin
         pm_new = cand0_s;
         dec    = 1'b0;
      end
   end

endmodule

// File: rtl/viterbi_decoder.sv
// ----------------------------------------------------------------------------
// viterbi_decoder
// Hard-decision rate-1/2 K=3 Viterbi decoder with register-exchange survivors.
// Decision delay is TB_DEPTH accepted symbols.
//   clk       : clock, rising edge
//   reset     : synchronous active-high reset (wins over in_valid/flush)
//   in_valid  : c is accepted this cycle
//   c         : received symbol {g0, g1}
//   flush     : (VITERBI_FLUSH_EN only) process an internal 2'b00 symbol
//               when in_valid is low
//   out_valid : registered one-cycle pulse per decoded bit
//   out_bit   : registered decoded bit, holds between pulses
// Optional feature macro: VITERBI_FLUSH_EN
// ----------------------------------------------------------------------------
module viterbi_decoder #(
   parameter int TB_DEPTH = 15,
   parameter int PM_W     = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  logic [1:0] c,
`ifdef VITERBI_FLUSH_EN
   input  logic       flush,
`endif
   output logic       out_valid,
   output logic       out_bit
);

   import viterbi_pkg::*;

   localparam int              FILL_W   = $clog2(TB_DEPTH + 1);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(TB_DEPTH);
   localparam logic [PM_W-1:0] PM_MAX   = {PM_W{1'b1}};

   logic [PM_W-1:0]     pm_r       [NUM_STATES];
   logic [TB_DEPTH-1:0] surv_r     [NUM_STATES];
   logic [FILL_W-1:0]   fill_r;
   logic                out_valid_r;
   logic                out_bit_r;

   logic                step_s;
   logic [1:0]          sym_s;
   logic [PM_W-1:0]     acs_pm_s   [NUM_STATES];
   logic [NUM_STATES-1:0] dec_s;
   logic [TB_DEPTH-1:0] surv_nxt_s [NUM_STATES];
   logic [PM_W-1:0]     min_pm_s;
   logic [PM_W-1:0]     best_pm_s;
   logic [1:0]          best_s;

`ifdef VITERBI_FLUSH_EN
   // A trellis step happens on a received symbol, or on a flush with a zero symbol.
   always_comb begin
      step_s = 1'b0;
      sym_s  = 2'b00;
      if (in_valid) begin
         step_s = 1'b1;
         sym_s  = c;
      end else if (flush) begin
         step_s = 1'b1;
         sym_s  = 2'b00;
      end else begin
         step_s = 1'b0;
         sym_s  = 2'b00;
      end
   end
`else
   // A trellis step happens only on a received symbol.
   always_comb begin
      step_s = 1'b0;
      sym_s  = 2'b00;
      if (in_valid) begin
         step_s = 1'b1;
         sym_s  = c;
      end else begin
         step_s = 1'b0;
         sym_s  = 2'b00;
      end
   end
`endif

   // Destination ns = {b, s1}; its predecessors are {s1,0} and {s1,1}.
   for (genvar ns = 0; ns < NUM_STATES; ns++) begin : g_acs
      localparam logic [1:0] NS = 2'(ns);
      localparam logic [1:0] P0 = {NS[0], 1'b0};
      localparam logic [1:0] P1 = {NS[0], 1'b1};

      logic [1:0] bm0_s;
      logic [1:0] bm1_s;

      assign bm0_s = branch_metric(sym_s, expected_sym(P0, NS[1]));
      assign bm1_s = branch_metric(sym_s, expected_sym(P1, NS[1]));

      viterbi_acs #(.PM_W(PM_W)) u_acs (
         .pm0    (pm_r[P0]),
         .pm1    (pm_r[P1]),
         .bm0    (bm0_s),
         .bm1    (bm1_s),
         .pm_new (acs_pm_s[ns]),
         .dec    (dec_s[ns])
      );

      // Register exchange: inherit the winner's history and append b.
      assign surv_nxt_s[ns] = dec_s[ns] ? {surv_r[P1][TB_DEPTH-2:0], NS[1]}
                                        : {surv_r[P0][TB_DEPTH-2:0], NS[1]};
   end

   // Minimum of the new metrics, subtracted so the smallest stored metric is 0.
   always_comb begin
      min_pm_s = acs_pm_s[0];
      for (int i = 1; i < NUM_STATES; i++) begin
         if (acs_pm_s[i] < min_pm_s) begin
            min_pm_s = acs_pm_s[i];
         end else begin
            min_pm_s = min_pm_s;
         end
      end
   end

   // Best state over the current (pre-update) metrics; strict compare keeps the lowest index on ties.
   always_comb begin
      best_s    = 2'd0;
      best_pm_s = pm_r[0];
      for (int i = 1; i < NUM_STATES; i++) begin
         if (pm_r[i] < best_pm_s) begin
            best_pm_s = pm_r[i];
            best_s    = 2'(i);
         end else begin
            best_pm_s = best_pm_s;
         end
      end
   end

   // Metrics, survivors, fill counter and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         pm_r[0]   <= {PM_W{1'b0}};
         surv_r[0] <= {TB_DEPTH{1'b0}};
         for (int i = 1; i < NUM_STATES; i++) begin
            pm_r[i]   <= PM_MAX;
            surv_r[i] <= {TB_DEPTH{1'b0}};
         end
         fill_r      <= {FILL_W{1'b0}};
         out_valid_r <= 1'b0;
         out_bit_r   <= 1'b0;
      end else if (step_s) begin
         for (int i = 0; i < NUM_STATES; i++) begin
            pm_r[i]   <= acs_pm_s[i] - min_pm_s;
            surv_r[i] <= surv_nxt_s[i];
         end
         if (fill_r != FILL_MAX) begin
            fill_r <= fill_r + FILL_W'(1);
         end
         out_valid_r <= (fill_r == FILL_MAX);
         // Before the pipe is full the oldest survivor bit is still the reset 0.
         out_bit_r   <= surv_r[best_s][TB_DEPTH-1];
      end else begin
         out_valid_r <= 1'b0;
      end
   end

   assign out_valid = out_valid_r;
   assign out_bit   = out_bit_r;

endmodule

// File: tb/tb_viterbi_decoder.sv
// ----------------------------------------------------------------------------
// tb_viterbi_decoder
// Directed bench for viterbi_decoder (TB_DEPTH=15, PM_W=4). Expected decoded
// bits are queued as symbols are accepted and popped on out_valid; path
// metrics are compared against a bench-side ACS model every cycle.
// ----------------------------------------------------------------------------
module tb_viterbi_decoder;

   localparam int TB_DEPTH = 15;
   localparam int PM_W     = 4;
   localparam int PM_MAX   = 15;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic [1:0] c;
`ifdef VITERBI_FLUSH_EN
   logic       flush;
`endif
   logic       out_valid;
   logic       out_bit;

   always #5 clk = ~clk;

   viterbi_decoder #(.TB_DEPTH(TB_DEPTH), .PM_W(PM_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .c         (c),
`ifdef VITERBI_FLUSH_EN
      .flush     (flush),
`endif
      .out_valid (out_valid),
      .out_bit   (out_bit)
   );

   int   errors = 0;
   int   checks = 0;
   bit   exp_q[$];
   int   mdl_pm[4];
   int   mdl_fill;
   logic last_bit;
   bit   chk_bits = 1'b1;
   int   n_out;

   logic [1:0] syms [10] = '{2'b00, 2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b11, 2'b10, 2'b11};
   bit         info [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Encoder output leaving state p = {s1,s2} on bit b.
   function automatic logic [1:0] enc(input int p, input int b);
      int s1, s2;
      s1 = (p >> 1) & 1;
      s2 = p & 1;
      return {1'(b ^ s1 ^ s2), 1'(b ^ s2)};
   endfunction

   function automatic int hd(input logic [1:0] a, input logic [1:0] b);
      logic [1:0] x;
      x = a ^ b;
      return int'(x[0]) + int'(x[1]);
   endfunction

   task automatic mdl_step(input logic [1:0] sym);
      int npm[4];
      int mn;
      for (int ns = 0; ns < 4; ns++) begin
         int p0, p1, b, c0, c1;
         p0 = (ns & 1) * 2;
         p1 = p0 + 1;
         b  = ns >> 1;
         c0 = mdl_pm[p0] + hd(sym, enc(p0, b));
         c1 = mdl_pm[p1] + hd(sym, enc(p1, b));
         if (c0 > PM_MAX) c0 = PM_MAX;
         if (c1 > PM_MAX) c1 = PM_MAX;
         npm[ns] = (c1 < c0) ? c1 : c0;
      end
      mn = npm[0];
      for (int i = 1; i < 4; i++) if (npm[i] < mn) mn = npm[i];
      for (int i = 0; i < 4; i++) mdl_pm[i] = npm[i] - mn;
   endtask

   task automatic check_metrics();
      int mn;
      mn = 1000;
      for (int i = 0; i < 4; i++) begin
         check("pm", 32'(dut.pm_r[i]), mdl_pm[i]);
         if (int'(dut.pm_r[i]) < mn) mn = int'(dut.pm_r[i]);
      end
      check("pm_min", mn, 0);
   endtask

   // One cycle of stimulus; queues the info bit of an accepted symbol.
   task automatic step(input bit v, input logic [1:0] sym, input bit fl, input bit ib);
      bit         acc;
      bit         exp_ov;
      logic [1:0] eff;
      in_valid = v;
      c        = sym;
`ifdef VITERBI_FLUSH_EN
      flush    = fl;
      acc      = v | fl;
`else
      acc      = v | (fl & 1'b0);
`endif
      eff    = v ? sym : 2'b00;
      exp_ov = acc && (mdl_fill == TB_DEPTH);
      if (acc) begin
         exp_q.push_back(ib);
         mdl_step(eff);
         if (mdl_fill < TB_DEPTH) mdl_fill++;
      end
      @(posedge clk);
      #1;
      check("out_valid", 32'(out_valid), 32'(exp_ov));
      if (out_valid === 1'b1 && exp_q.size() > 0) begin
         bit e;
         n_out++;
         e = exp_q.pop_front();
         if (chk_bits) begin
            check("out_bit", 32'(out_bit), 32'(e));
            last_bit = e;
         end else begin
            last_bit = out_bit;
         end
      end else begin
         check("out_bit_hold", 32'(out_bit), 32'(last_bit));
      end
      check_metrics();
   endtask

   task automatic do_reset(input bit v, input logic [1:0] sym);
      reset    = 1'b1;
      in_valid = v;
      c        = sym;
`ifdef VITERBI_FLUSH_EN
      flush    = 1'b1;
`endif
      @(posedge clk);
      #1;
      reset    = 1'b0;
      in_valid = 1'b0;
`ifdef VITERBI_FLUSH_EN
      flush    = 1'b0;
`endif
      mdl_pm   = '{0, PM_MAX, PM_MAX, PM_MAX};
      mdl_fill = 0;
      exp_q.delete();
      last_bit = 1'b0;
      n_out    = 0;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_bit", 32'(out_bit), 0);
      check_metrics();
   endtask

   // Full 25-symbol frame; optional corruption of symbol 3 and 3-cycle gaps.
   task automatic run_stream(input bit err, input bit gaps);
      logic [1:0] s;
      bit         ib;
      for (int k = 0; k < 25; k++) begin
         s  = (k < 10) ? syms[k] : 2'b00;
         ib = (k < 10) ? info[k] : 1'b0;
         if (err && k == 3) s = 2'b10;
         step(1'b1, s, 1'b0, ib);
         if (gaps && (k % 2 == 1)) begin
            for (int g = 0; g < 3; g++) step(1'b0, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
         end
      end
      check("n_out", n_out, 10);
   endtask

   initial begin
      reset    = 1'b0;
      in_valid = 1'b0;
      c        = 2'b00;
`ifdef VITERBI_FLUSH_EN
      flush    = 1'b0;
`endif
      do_reset(1'b0, 2'b00);

      // Error-free frame
      run_stream(1'b0, 1'b0);

      // Single channel error
      do_reset(1'b0, 2'b00);
      run_stream(1'b1, 1'b0);

      // Valid gaps
      do_reset(1'b0, 2'b00);
      run_stream(1'b0, 1'b1);

      // Reset mid-stream at symbol 20 (with in_valid high), then replay
      do_reset(1'b0, 2'b00);
      for (int k = 0; k < 20; k++) begin
         step(1'b1, (k < 10) ? syms[k] : 2'b00, 1'b0, (k < 10) ? info[k] : 1'b0);
      end
      check("n_out_pre_rst", n_out, 5);
      do_reset(1'b1, 2'b11);
      run_stream(1'b0, 1'b0);

      // Random noise: metric normalisation and saturation
      do_reset(1'b0, 2'b00);
      chk_bits = 1'b0;
      for (int k = 0; k < 200; k++) step(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
      chk_bits = 1'b1;

`ifdef VITERBI_FLUSH_EN
      // Zero-tailed frame drained by flush; flush alongside in_valid is ignored
      do_reset(1'b0, 2'b00);
      for (int k = 0; k < 10; k++) step(1'b1, syms[k], 1'(k % 2), info[k]);
      for (int k = 0; k < 15; k++) step(1'b0, 2'($urandom_range(0, 3)), 1'b1, 1'b0);
      check("n_out_flush", n_out, 10);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
